// File: rtl/encoder_poll_ctrl.sv
// encoder_poll_ctrl: AXI4-Lite master that enables the quadrature encoder,
// samples POSITION/STATUS every PERIOD cycles, publishes position/delta/
// direction with a one-cycle strobe, services clear requests and reports
// bus errors and sample overruns.
// Ports:
//   aclk, aresetn            clock, async active-low reset
//   m_aw_*, m_w_*, m_b_*     AXI4-Lite write address/data/response
//   m_ar_*, m_r_*            AXI4-Lite read address/data
//   start                    level, run while high
//   clr_req                  pulse, request a position clear
//   position/delta/direction last published sample
//   sample_valid             one-cycle strobe on publish
//   busy                     FSM not in IDLE
//   err_resp/err_overrun     sticky error flags, cleared by err_clr
module encoder_poll_ctrl #(
  parameter int unsigned PERIOD = 1000,
  parameter logic [31:0] BASE   = 32'h0
) (
  input  logic        aclk,
  input  logic        aresetn,
  output logic [31:0] m_aw_addr,
  output logic        m_aw_valid,
  input  logic        m_aw_ready,
  output logic [31:0] m_w_data,
  output logic [3:0]  m_w_strb,
  output logic        m_w_valid,
  input  logic        m_w_ready,
  input  logic [1:0]  m_b_resp,
  input  logic        m_b_valid,
  output logic        m_b_ready,
  output logic [31:0] m_ar_addr,
  output logic        m_ar_valid,
  input  logic        m_ar_ready,
  input  logic [31:0] m_r_data,
  input  logic [1:0]  m_r_resp,
  input  logic        m_r_valid,
  output logic        m_r_ready,
  input  logic        start,
  input  logic        clr_req,
  output logic [31:0] position,
  output logic [31:0] delta,
  output logic        direction,
  output logic        sample_valid,
  output logic        busy,
  output logic        err_resp,
  output logic        err_overrun,
  input  logic        err_clr
);

  localparam int unsigned   TW          = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [TW-1:0] TICK_AT     = TW'(PERIOD - 1);
  localparam logic [31:0]   OFF_CTRL    = 32'h0;
  localparam logic [31:0]   OFF_STATUS  = 32'h4;
  localparam logic [31:0]   OFF_POS     = 32'h8;
  localparam logic [31:0]   CTRL_OFF    = 32'h0;
  localparam logic [31:0]   CTRL_EN     = 32'h1;
  localparam logic [31:0]   CTRL_CLR_EN = 32'h3;
  localparam logic [1:0]    RESP_OKAY   = 2'b00;

  typedef enum logic [3:0] {
    S_IDLE, S_EN_WR, S_EN_B, S_WAIT, S_RD_POS, S_RD_POS_R, S_RD_ST, S_RD_ST_R,
    S_PUBLISH, S_CLR_WR, S_CLR_B, S_UNCLR_WR, S_UNCLR_B, S_DIS_WR, S_DIS_B
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          force_tick_q, force_tick_d;
  logic          clr_pend_q, clr_pend_d;
  logic [31:0]   prev_pos_q, prev_pos_d;
  logic [31:0]   pos_cap_q, pos_cap_d;
  logic [31:0]   aw_addr_q, aw_addr_d;
  logic          aw_valid_q, aw_valid_d;
  logic [31:0]   w_data_q, w_data_d;
  logic [3:0]    w_strb_q, w_strb_d;
  logic          w_valid_q, w_valid_d;
  logic          b_ready_q, b_ready_d;
  logic [31:0]   ar_addr_q, ar_addr_d;
  logic          ar_valid_q, ar_valid_d;
  logic          r_ready_q, r_ready_d;
  logic [31:0]   position_q, position_d;
  logic [31:0]   delta_q, delta_d;
  logic          direction_q, direction_d;
  logic          sample_valid_q, sample_valid_d;
  logic          busy_q, busy_d;
  logic          err_resp_q, err_resp_d;
  logic          err_overrun_q, err_overrun_d;

  logic          tick, clr_pend_w, wr_done, set_resp, set_ovr;
  logic          start_wr, start_rd;
  logic [31:0]   wr_data, rd_addr;

  // State and output registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q        <= S_IDLE;
      timer_q        <= '0;
      force_tick_q   <= 1'b0;
      clr_pend_q     <= 1'b0;
      prev_pos_q     <= '0;
      pos_cap_q      <= '0;
      aw_addr_q      <= '0;
      aw_valid_q     <= 1'b0;
      w_data_q       <= '0;
      w_strb_q       <= '0;
      w_valid_q      <= 1'b0;
      b_ready_q      <= 1'b0;
      ar_addr_q      <= '0;
      ar_valid_q     <= 1'b0;
      r_ready_q      <= 1'b0;
      position_q     <= '0;
      delta_q        <= '0;
      direction_q    <= 1'b0;
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      err_resp_q     <= 1'b0;
      err_overrun_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      force_tick_q   <= force_tick_d;
      clr_pend_q     <= clr_pend_d;
      prev_pos_q     <= prev_pos_d;
      pos_cap_q      <= pos_cap_d;
      aw_addr_q      <= aw_addr_d;
      aw_valid_q     <= aw_valid_d;
      w_data_q       <= w_data_d;
      w_strb_q       <= w_strb_d;
      w_valid_q      <= w_valid_d;
      b_ready_q      <= b_ready_d;
      ar_addr_q      <= ar_addr_d;
      ar_valid_q     <= ar_valid_d;
      r_ready_q      <= r_ready_d;
      position_q     <= position_d;
      delta_q        <= delta_d;
      direction_q    <= direction_d;
      sample_valid_q <= sample_valid_d;
      busy_q         <= busy_d;
      err_resp_q     <= err_resp_d;
      err_overrun_q  <= err_overrun_d;
    end
  end

  // Next-state, bus sequencing and output logic
  always_comb begin
    state_d        = state_q;
    force_tick_d   = 1'b0;
    prev_pos_d     = prev_pos_q;
    pos_cap_d      = pos_cap_q;
    aw_addr_d      = aw_addr_q;
    aw_valid_d     = aw_valid_q;
    w_data_d       = w_data_q;
    w_strb_d       = w_strb_q;
    w_valid_d      = w_valid_q;
    b_ready_d      = b_ready_q;
    ar_addr_d      = ar_addr_q;
    ar_valid_d     = ar_valid_q;
    r_ready_d      = r_ready_q;
    position_d     = position_q;
    delta_d        = delta_q;
    direction_d    = direction_q;
    sample_valid_d = 1'b0;
    set_resp       = 1'b0;
    start_wr       = 1'b0;
    start_rd       = 1'b0;
    wr_data        = CTRL_OFF;
    rd_addr        = BASE + OFF_POS;

    tick       = (state_q != S_IDLE) && ((timer_q == TICK_AT) || force_tick_q);
    clr_pend_w = clr_pend_q | clr_req;
    clr_pend_d = clr_pend_w;
    // Clear wins over a coincident tick, which is then lost as an overrun
    set_ovr    = tick && ((state_q != S_WAIT) || clr_pend_w);
    timer_d    = ((state_q == S_IDLE) || (timer_q == TICK_AT)) ? '0 : timer_q + TW'(1);

    // Each channel drops independently once its handshake is seen
    if (aw_valid_q && m_aw_ready) aw_valid_d = 1'b0;
    if (w_valid_q && m_w_ready)   w_valid_d  = 1'b0;
    if (ar_valid_q && m_ar_ready) ar_valid_d = 1'b0;
    wr_done = (!aw_valid_q || m_aw_ready) && (!w_valid_q || m_w_ready);

    case (state_q)
      S_IDLE: if (start) begin
        state_d  = S_EN_WR;
        start_wr = 1'b1;
        wr_data  = CTRL_EN;
      end
      S_EN_WR, S_CLR_WR, S_UNCLR_WR, S_DIS_WR: if (wr_done) begin
        b_ready_d = 1'b1;
        case (state_q)
          S_EN_WR:  state_d = S_EN_B;
          S_CLR_WR: state_d = S_CLR_B;
          S_UNCLR_WR: state_d = S_UNCLR_B;
          default:  state_d = S_DIS_B;
        endcase
      end
      S_EN_B, S_CLR_B, S_UNCLR_B, S_DIS_B: if (m_b_valid) begin
        b_ready_d = 1'b0;
        set_resp  = (m_b_resp != RESP_OKAY);
        case (state_q)
          S_EN_B: begin
            state_d      = S_WAIT;
            prev_pos_d   = '0;
            force_tick_d = 1'b1;
          end
          S_CLR_B: begin
            state_d  = S_UNCLR_WR;
            start_wr = 1'b1;
            wr_data  = CTRL_EN;
          end
          S_UNCLR_B: begin
            state_d    = S_WAIT;
            prev_pos_d = '0;
            clr_pend_d = 1'b0;
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_WAIT: begin
        if (clr_pend_w) begin
          state_d  = S_CLR_WR;
          start_wr = 1'b1;
          wr_data  = CTRL_CLR_EN;
        end else if (!start) begin
          state_d  = S_DIS_WR;
          start_wr = 1'b1;
          wr_data  = CTRL_OFF;
        end else if (tick) begin
          state_d  = S_RD_POS;
          start_rd = 1'b1;
          rd_addr  = BASE + OFF_POS;
        end
      end
      S_RD_POS, S_RD_ST: if (m_ar_ready) begin
        r_ready_d = 1'b1;
        state_d   = (state_q == S_RD_POS) ? S_RD_POS_R : S_RD_ST_R;
      end
      S_RD_POS_R: if (m_r_valid) begin
        r_ready_d = 1'b0;
        if (m_r_resp == RESP_OKAY) begin
          pos_cap_d = m_r_data;
          state_d   = S_RD_ST;
          start_rd  = 1'b1;
          rd_addr   = BASE + OFF_STATUS;
        end else begin
          set_resp = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_RD_ST_R: if (m_r_valid) begin
        r_ready_d = 1'b0;
        if (m_r_resp == RESP_OKAY) begin
          state_d        = S_PUBLISH;
          position_d     = pos_cap_q;
          delta_d        = pos_cap_q - prev_pos_q;
          direction_d    = m_r_data[0];
          prev_pos_d     = pos_cap_q;
          sample_valid_d = 1'b1;
        end else begin
          set_resp = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_PUBLISH: state_d = S_WAIT;
      default:   state_d = S_IDLE;
    endcase

    if (start_wr) begin
      aw_valid_d = 1'b1;
      w_valid_d  = 1'b1;
      aw_addr_d  = BASE + OFF_CTRL;
      w_data_d   = wr_data;
      w_strb_d   = 4'hF;
    end
    if (start_rd) begin
      ar_valid_d = 1'b1;
      ar_addr_d  = rd_addr;
    end

    // A new error in the same cycle as err_clr keeps the flag set
    err_resp_d    = (err_resp_q & ~err_clr) | set_resp;
    err_overrun_d = (err_overrun_q & ~err_clr) | set_ovr;
    busy_d        = (state_d != S_IDLE);
  end

  assign m_aw_addr    = aw_addr_q;
  assign m_aw_valid   = aw_valid_q;
  assign m_w_data     = w_data_q;
  assign m_w_strb     = w_strb_q;
  assign m_w_valid    = w_valid_q;
  assign m_b_ready    = b_ready_q;
  assign m_ar_addr    = ar_addr_q;
  assign m_ar_valid   = ar_valid_q;
  assign m_r_ready    = r_ready_q;
  assign position     = position_q;
  assign delta        = delta_q;
  assign direction    = direction_q;
  assign sample_valid = sample_valid_q;
  assign busy         = busy_q;
  assign err_resp     = err_resp_q;
  assign err_overrun  = err_overrun_q;

endmodule

// File: tb/tb_encoder_poll_ctrl.sv
// Directed bench for encoder_poll_ctrl: a behavioural AXI4-Lite encoder slave,
// scoreboard queues for expected writes, reads and published samples.
module tb_encoder_poll_ctrl;
  localparam int unsigned PERIOD = 32;
  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam logic [31:0] A_CTRL = BASE + 32'h0;
  localparam logic [31:0] A_ST   = BASE + 32'h4;
  localparam logic [31:0] A_POS  = BASE + 32'h8;

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic [31:0] pos; logic [31:0] dlt; logic dir; } smp_t;

  logic        aclk, aresetn;
  logic [31:0] m_aw_addr, m_w_data, m_ar_addr, m_r_data;
  logic        m_aw_valid, m_aw_ready, m_w_valid, m_w_ready;
  logic [3:0]  m_w_strb;
  logic [1:0]  m_b_resp, m_r_resp;
  logic        m_b_valid, m_b_ready, m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
  logic        start, clr_req, err_clr;
  logic [31:0] position, delta;
  logic        direction, sample_valid, busy, err_resp, err_overrun;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int sample_cnt = 0;
  int sv_cyc[$];
  wr_t exp_wr[$];
  logic [31:0] exp_rd[$];
  smp_t exp_smp[$];

  // slave knobs, written by the stimulus
  logic [31:0] pos_val = '0;
  logic [31:0] st_val = '0;
  int stall_cnt = 0;
  bit wr_hold = 1'b0;
  bit pos_err = 1'b0;

  encoder_poll_ctrl #(.PERIOD(PERIOD), .BASE(BASE)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m_aw_addr(m_aw_addr), .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
    .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_valid(m_w_valid), .m_w_ready(m_w_ready),
    .m_b_resp(m_b_resp), .m_b_valid(m_b_valid), .m_b_ready(m_b_ready),
    .m_ar_addr(m_ar_addr), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
    .start(start), .clr_req(clr_req),
    .position(position), .delta(delta), .direction(direction),
    .sample_valid(sample_valid), .busy(busy),
    .err_resp(err_resp), .err_overrun(err_overrun), .err_clr(err_clr)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic wr_t mk_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    return w;
  endfunction

  function automatic smp_t mk_smp(input logic [31:0] p, input logic [31:0] d, input logic r);
    smp_t s;
    s.pos = p;
    s.dlt = d;
    s.dir = r;
    return s;
  endfunction

  // Zero-wait encoder slave: ready in the same cycle, response one cycle later
  initial begin : slave
    logic aw_got, w_got, nb, nr;
    logic [31:0] aw_a, w_d, nr_d;
    logic [3:0] w_s;
    logic [1:0] nr_rsp;
    wr_t e;
    aw_got = 1'b0; w_got = 1'b0; aw_a = '0; w_d = '0; w_s = '0;
    m_aw_ready = 1'b1; m_w_ready = 1'b1; m_ar_ready = 1'b1;
    m_b_valid = 1'b0; m_b_resp = 2'b00; m_r_valid = 1'b0; m_r_data = '0; m_r_resp = 2'b00;
    nr_d = '0; nr_rsp = 2'b00;
    forever begin
      @(posedge aclk);
      nb = m_b_valid;
      nr = m_r_valid;
      nr_d = m_r_data;
      nr_rsp = m_r_resp;
      if (!aresetn) begin
        aw_got = 1'b0; w_got = 1'b0; nb = 1'b0; nr = 1'b0;
      end else begin
        if (m_b_valid && m_b_ready) nb = 1'b0;
        if (m_r_valid && m_r_ready) nr = 1'b0;
        if (m_aw_valid && m_aw_ready) begin aw_got = 1'b1; aw_a = m_aw_addr; end
        if (m_w_valid && m_w_ready) begin w_got = 1'b1; w_d = m_w_data; w_s = m_w_strb; end
        if (aw_got && w_got) begin
          chk("wr_expected", 32'(exp_wr.size() > 0), 32'd1);
          if (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            chk("wr_addr", aw_a, e.addr);
            chk("wr_data", w_d, e.data);
          end
          chk("wr_strb", 32'(w_s), 32'hF);
          aw_got = 1'b0; w_got = 1'b0; nb = 1'b1;
        end
        if (m_ar_valid && m_ar_ready) begin
          chk("rd_expected", 32'(exp_rd.size() > 0), 32'd1);
          if (exp_rd.size() > 0) chk("rd_addr", m_ar_addr, exp_rd.pop_front());
          nr = 1'b1;
          nr_rsp = 2'b00;
          nr_d = (m_ar_addr == A_POS) ? pos_val : st_val;
          if (m_ar_addr == A_POS && pos_err) begin nr_rsp = 2'b10; pos_err = 1'b0; end
        end
        if (m_ar_valid && stall_cnt > 0) stall_cnt--;
      end
      #1;
      m_b_valid = nb; m_b_resp = 2'b00;
      m_r_valid = nr; m_r_data = nr_d; m_r_resp = nr_rsp;
      m_ar_ready = (stall_cnt == 0);
      m_aw_ready = !wr_hold && !aw_got;
      m_w_ready = !wr_hold && !w_got;
    end
  end

  // Published-sample scoreboard and channel-overlap monitor
  always @(negedge aclk) begin
    smp_t s;
    if (aresetn) begin
      if (m_ar_valid) chk("no_overlap", 32'(m_aw_valid | m_w_valid), 32'd0);
      if (sample_valid) begin
        sample_cnt++;
        sv_cyc.push_back(cyc);
        chk("smp_expected", 32'(exp_smp.size() > 0), 32'd1);
        if (exp_smp.size() > 0) begin
          s = exp_smp.pop_front();
          chk("position", position, s.pos);
          chk("delta", delta, s.dlt);
          chk("direction", 32'(direction), 32'(s.dir));
        end
      end
    end
  end

  task automatic wait_samples(input int n, input int budget);
    int k = 0;
    while (sample_cnt < n && k < budget) begin
      @(negedge aclk); #1;
      k++;
    end
    chk("sample_arrived", 32'(sample_cnt >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      @(negedge aclk); #1;
      k++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_aw"}, {m_aw_addr[30:0], m_aw_valid}, 32'd0);
    chk({tag, "_w"}, {m_w_data[26:0], m_w_strb, m_w_valid}, 32'd0);
    chk({tag, "_ar"}, {m_ar_addr[29:0], m_ar_valid, m_r_ready}, 32'd0);
    chk({tag, "_ctl"}, 32'({m_b_ready, busy, sample_valid, direction, err_resp, err_overrun}), 32'd0);
    chk({tag, "_pos"}, position | delta, 32'd0);
  endtask

  initial begin : stim
    int k;
    aresetn = 1'b0; start = 1'b0; clr_req = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge aclk);
    chk_all_zero("reset");
    aresetn = 1'b1;
    @(negedge aclk); #1;

    // enable, then forced first sample
    pos_val = 32'd20; st_val = 32'd1;
    exp_wr.push_back(mk_wr(A_CTRL, 32'h1));
    exp_rd.push_back(A_POS); exp_rd.push_back(A_ST);
    exp_smp.push_back(mk_smp(32'd20, 32'd20, 1'b1));
    start = 1'b1;
    wait_samples(1, 40);
    chk("busy_running", 32'(busy), 32'd1);

    // negative position, then an unchanged one; periodic spacing
    pos_val = 32'hFFFF_FFEC; st_val = 32'd0;
    repeat (2) begin exp_rd.push_back(A_POS); exp_rd.push_back(A_ST); end
    exp_smp.push_back(mk_smp(32'hFFFF_FFEC, 32'hFFFF_FFD8, 1'b0));
    exp_smp.push_back(mk_smp(32'hFFFF_FFEC, 32'h0, 1'b0));
    wait_samples(2, 80);
    wait_samples(3, 80);
    chk("tick_spacing", 32'(sv_cyc[2] - sv_cyc[1]), PERIOD);

    // clear request coinciding with a tick (tick cycle = publish - 5 + PERIOD)
    chk("ovr_before_clr", 32'(err_overrun), 32'd0);
    pos_val = 32'd5; st_val = 32'd1;
    exp_wr.push_back(mk_wr(A_CTRL, 32'h3));
    exp_wr.push_back(mk_wr(A_CTRL, 32'h1));
    exp_rd.push_back(A_POS); exp_rd.push_back(A_ST);
    exp_smp.push_back(mk_smp(32'd5, 32'd5, 1'b1));
    repeat (PERIOD - 5) @(posedge aclk);
    #1 clr_req = 1'b1;
    @(posedge aclk);
    #1 clr_req = 1'b0;
    wait_samples(4, 80);
    chk("ovr_after_clr", 32'(err_overrun), 32'd1);

    // SLVERR on the POSITION read: flagged, nothing published
    pos_err = 1'b1;
    exp_rd.push_back(A_POS);
    repeat (PERIOD) @(negedge aclk);
    #1;
    chk("err_resp_set", 32'(err_resp), 32'd1);
    chk("no_smp_on_err", 32'(sample_cnt), 32'd4);
    chk("pos_held", position, 32'd5);
    err_clr = 1'b1;
    @(negedge aclk); #1;
    err_clr = 1'b0;
    chk("err_resp_clr", 32'(err_resp), 32'd0);
    chk("err_ovr_clr", 32'(err_overrun), 32'd0);

    // AR stalled past a whole period: overrun, exactly one sample, then stop
    stall_cnt = PERIOD + 10;
    pos_val = 32'd7; st_val = 32'd0;
    exp_rd.push_back(A_POS); exp_rd.push_back(A_ST);
    exp_smp.push_back(mk_smp(32'd7, 32'd2, 1'b0));
    wait_samples(5, 4 * PERIOD);
    start = 1'b0;
    exp_wr.push_back(mk_wr(A_CTRL, 32'h0));
    chk("ovr_after_stall", 32'(err_overrun), 32'd1);
    wait_idle(40);
    chk("one_smp_stall", 32'(sample_cnt), 32'd5);

    // reset while a write is held on the bus
    wr_hold = 1'b1;
    start = 1'b1;
    k = 0;
    while (m_w_valid !== 1'b1 && k < 20) begin @(negedge aclk); #1; k++; end
    chk("w_valid_seen", 32'(m_w_valid), 32'd1);
    aresetn = 1'b0;
    #1;
    chk_all_zero("async_rst");
    repeat (2) @(negedge aclk);
    wr_hold = 1'b0;
    pos_val = 32'd9; st_val = 32'd1;
    exp_wr.push_back(mk_wr(A_CTRL, 32'h1));
    exp_rd.push_back(A_POS); exp_rd.push_back(A_ST);
    exp_smp.push_back(mk_smp(32'd9, 32'd9, 1'b1));
    aresetn = 1'b1;
    wait_samples(6, 60);
    start = 1'b0;
    exp_wr.push_back(mk_wr(A_CTRL, 32'h0));
    wait_idle(40);
    repeat (3) @(negedge aclk);

    chk("wr_q_drained", 32'(exp_wr.size()), 32'd0);
    chk("rd_q_drained", 32'(exp_rd.size()), 32'd0);
    chk("smp_q_drained", 32'(exp_smp.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
